maze_seq_ctrl: RTL
==================

MAZE_SEQ_CTRL -- requirements
Module: maze_seq_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port row_valid, input, 1 bit: host row available.
REQ-004 The block SHALL have the port row_data, input, 15 bits: one maze row; bit x = cell (x,y), 1 = wall.
REQ-005 The block SHALL have the port row_ready, output, 1 bit: row accepted when row_valid && row_ready.
REQ-006 The block SHALL have the port slv_in_valid, output, 1 bit: solver maze-input strobe.
REQ-007 The block SHALL have the port slv_maze, output, 1 bit: serial maze cell to the solver.
REQ-008 The block SHALL have the ports slv_out_valid (input, 1), slv_maze_not_valid (input, 1), slv_out_x (input, 4) and slv_out_y (input, 4): solver result stream.
REQ-009 The block SHALL have the ports res_valid (output, 1), res_x (output, 4) and res_y (output, 4): forwarded path step.
REQ-010 The block SHALL have the ports done (output, 1), status (output, 2) and path_len (output, 8): job completion report.

Function
REQ-011 The state machine SHALL have the states IDLE, LOAD, FEED, WAIT, STREAM and DONE.
REQ-012 row_ready SHALL be 1 in IDLE and LOAD, and 0 in all other states.
REQ-013 In IDLE, an accepted row SHALL become row y=0 and move the FSM to LOAD.
REQ-014 Rows y=1..14 SHALL be accepted in LOAD; after the row y=14 handshake the FSM SHALL enter FEED on the next cycle.
REQ-015 FEED SHALL drive slv_in_valid=1 for exactly 225 consecutive cycles.
REQ-016 In FEED, slv_maze SHALL present cell index i = y*15+x on cycle i, i.e. row-major, x fastest.
REQ-017 In FEED, the first slv_in_valid SHALL be asserted the cycle after the last row handshake.
REQ-018 After the 225th FEED cycle, the FSM SHALL enter WAIT with slv_in_valid=0.
REQ-019 slv_maze SHALL be 0 whenever slv_in_valid=0.
REQ-020 In WAIT, slv_maze_not_valid=1 SHALL move the FSM to DONE with status=NOT_VALID and path_len=0.
REQ-021 In WAIT, slv_out_valid=1 SHALL move the FSM to STREAM, and that first step SHALL be forwarded.
REQ-022 If slv_maze_not_valid=1 and slv_out_valid=1 are asserted in the same WAIT cycle, NOT_VALID SHALL win and the step SHALL be discarded.
REQ-023 Each slv_out_valid cycle SHALL produce res_valid=1 one cycle later, carrying that cycle's slv_out_x/slv_out_y and incrementing the path count.
REQ-024 The path count SHALL saturate at 255.
REQ-025 The first cycle with slv_out_valid=0 in STREAM SHALL move the FSM to DONE with status=OK and path_len=count.
REQ-026 done SHALL pulse for exactly one cycle in DONE; status and path_len SHALL hold until the next done; the FSM SHALL then return to IDLE.
REQ-027 slv_out_valid and slv_maze_not_valid SHALL be ignored outside WAIT/STREAM, and slv_maze_not_valid SHALL also be ignored in STREAM.
REQ-028 status encoding SHALL be: 0 = OK, 1 = NOT_VALID, 2 = TIMEOUT, 3 = reserved.

Reset
REQ-029 When rst=1 at a rising edge, the FSM SHALL enter IDLE from any state, including mid-LOAD and mid-FEED.
REQ-030 On reset, row_ready SHALL be 0 during reset and 1 on the first cycle after it; slv_in_valid, slv_maze, res_valid, res_x, res_y, done, status, path_len and all counters SHALL be 0.
REQ-031 A partially loaded maze SHALL be discarded on reset; no solver strobe SHALL follow reset.

Configuration
REQ-032 With MAZE_SEQ_TIMEOUT_EN defined, a 12-bit watchdog SHALL count WAIT cycles; on reaching 3000, the FSM SHALL enter DONE with status=TIMEOUT and path_len=0.
REQ-033 Without MAZE_SEQ_TIMEOUT_EN, WAIT SHALL last indefinitely, status SHALL never be TIMEOUT, and no watchdog logic SHALL exist.

Structure
REQ-034 Package maze_seq_pkg SHALL hold MAZE_DIM=15, MAZE_CELLS=225, WAIT_TIMEOUT=3000, the state enum and the status enum.
REQ-035 Sub-module maze_shift_buf SHALL implement the 225-bit row-load / serial-shift storage; the FSM and counters SHALL stay in maze_seq_ctrl.

Verification
REQ-036 The bench SHALL load an open maze of all zeros, respond 29 path steps -> slv_in_valid exactly 225 cycles, 29 res_valid steps with matching coordinates, done with status=0 and path_len=29.
REQ-037 The bench SHALL load a maze with only cell (14,14)=1 -> slv_maze=1 solely on FEED cycle 224.
REQ-038 The bench SHALL assert slv_maze_not_valid 10 cycles into WAIT -> done with status=1, path_len=0, and no res_valid.
REQ-039 The bench SHALL assert slv_maze_not_valid and slv_out_valid in the same WAIT cycle -> status=1 and no res_valid.
REQ-040 With MAZE_SEQ_TIMEOUT_EN defined and a silent solver -> done at WAIT cycle 3000 with status=2; without the macro -> no done after 5000 cycles.
REQ-041 The bench SHALL assert rst at FEED cycle 100 -> slv_in_valid=0 the next cycle and row_ready=1 after release; a subsequent full job SHALL complete with status=0.

Source files
------------

// File: rtl/maze_seq_pkg.sv
// Shared constants, FSM state and status encodings for the maze sequencer.
package maze_seq_pkg;

  localparam int MAZE_DIM     = 15;
  localparam int MAZE_CELLS   = 225;
  localparam int WAIT_TIMEOUT = 3000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FEED,
    WAIT,
    STREAM,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OK        = 2'd0,
    NOT_VALID = 2'd1,
    TIMEOUT   = 2'd2,
    RESERVED  = 2'd3
  } status_t;

endpackage

// File: rtl/maze_shift_buf.sv
// Maze storage: rows shift in 15 bits at a time, cells shift out one per cycle from bit 0.
module maze_shift_buf
  import maze_seq_pkg::*;
(
  input  logic                clk,
  input  logic                i_load,
  input  logic [MAZE_DIM-1:0] i_row,
  input  logic                i_shift,
  output logic                o_cell
);

  logic [MAZE_CELLS-1:0] r_cells;

  // After 15 row loads row y sits at bits [y*15 +: 15], so bit 0 is cell (0,0).
  always_ff @(posedge clk) begin
    if (i_load)
      r_cells <= {i_row, r_cells[MAZE_CELLS-1:MAZE_DIM]};
    else if (i_shift)
      r_cells <= {1'b0, r_cells[MAZE_CELLS-1:1]};
  end

  assign o_cell = r_cells[0];

endmodule

// File: rtl/maze_seq_ctrl.sv
// Maze job sequencer: loads 15 rows, serialises them to the solver, forwards the path.
// Optional WAIT watchdog enabled by defining MAZE_SEQ_TIMEOUT_EN.
module maze_seq_ctrl
  import maze_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                row_valid,
  input  logic [MAZE_DIM-1:0] row_data,
  output logic                row_ready,
  output logic                slv_in_valid,
  output logic                slv_maze,
  input  logic                slv_out_valid,
  input  logic                slv_maze_not_valid,
  input  logic [3:0]          slv_out_x,
  input  logic [3:0]          slv_out_y,
  output logic                res_valid,
  output logic [3:0]          res_x,
  output logic [3:0]          res_y,
  output logic                done,
  output logic [1:0]          status,
  output logic [7:0]          path_len
);

  state_t     r_state;
  logic [3:0] r_row_cnt;
  logic [7:0] r_feed_cnt;
  logic [7:0] r_path_cnt;
  logic       r_slv_in_valid;
  logic       r_res_valid;
  logic [3:0] r_res_x;
  logic [3:0] r_res_y;
  logic       r_done;
  status_t    r_status;
  logic [7:0] r_path_len;
`ifdef MAZE_SEQ_TIMEOUT_EN
  logic [11:0] r_wd;
`endif

  logic w_row_ready;
  logic w_row_hs;
  logic w_cell;

  // Ready is gated by rst so the host never sees a handshake during reset.
  assign w_row_ready = ~rst & ((r_state == IDLE) | (r_state == LOAD));
  assign w_row_hs    = row_valid & w_row_ready;

  maze_shift_buf u_buf (
    .clk     (clk),
    .i_load  (w_row_hs),
    .i_row   (row_data),
    .i_shift (r_slv_in_valid),
    .o_cell  (w_cell)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_row_cnt      <= '0;
      r_feed_cnt     <= '0;
      r_path_cnt     <= '0;
      r_slv_in_valid <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_x        <= '0;
      r_res_y        <= '0;
      r_done         <= 1'b0;
      r_status       <= OK;
      r_path_len     <= '0;
`ifdef MAZE_SEQ_TIMEOUT_EN
      r_wd           <= '0;
`endif
    end else begin
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (row_valid) begin
            r_state   <= LOAD;
            r_row_cnt <= 4'd1;
          end
        end
        LOAD: begin
          if (row_valid) begin
            if (r_row_cnt == 4'(MAZE_DIM - 1)) begin
              r_state        <= FEED;
              r_slv_in_valid <= 1'b1;
              r_feed_cnt     <= '0;
            end else begin
              r_row_cnt <= r_row_cnt + 4'd1;
            end
          end
        end
        FEED: begin
          r_feed_cnt <= r_feed_cnt + 8'd1;
          if (r_feed_cnt == 8'(MAZE_CELLS - 1)) begin
            r_state        <= WAIT;
            r_slv_in_valid <= 1'b0;
            r_path_cnt     <= '0;
`ifdef MAZE_SEQ_TIMEOUT_EN
            r_wd           <= '0;
`endif
          end
        end
        WAIT: begin
          // not_valid takes priority and drops any simultaneous step.
          if (slv_maze_not_valid) begin
            r_state    <= DONE;
            r_done     <= 1'b1;
            r_status   <= NOT_VALID;
            r_path_len <= '0;
          end else if (slv_out_valid) begin
            r_state     <= STREAM;
            r_res_valid <= 1'b1;
            r_res_x     <= slv_out_x;
            r_res_y     <= slv_out_y;
            r_path_cnt  <= 8'd1;
          end
`ifdef MAZE_SEQ_TIMEOUT_EN
          else if (r_wd == 12'(WAIT_TIMEOUT - 1)) begin
            r_state    <= DONE;
            r_done     <= 1'b1;
            r_status   <= TIMEOUT;
            r_path_len <= '0;
          end else begin
            r_wd <= r_wd + 12'd1;
          end
`endif
        end
        STREAM: begin
          if (slv_out_valid) begin
            r_res_valid <= 1'b1;
            r_res_x     <= slv_out_x;
            r_res_y     <= slv_out_y;
            r_path_cnt  <= (r_path_cnt == 8'hFF) ? r_path_cnt : r_path_cnt + 8'd1;
          end else begin
            r_state    <= DONE;
            r_done     <= 1'b1;
            r_status   <= OK;
            r_path_len <= r_path_cnt;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign row_ready    = w_row_ready;
  assign slv_in_valid = r_slv_in_valid;
  assign slv_maze     = r_slv_in_valid & w_cell;
  assign res_valid    = r_res_valid;
  assign res_x        = r_res_x;
  assign res_y        = r_res_y;
  assign done         = r_done;
  assign status       = r_status;
  assign path_len     = r_path_len;

endmodule
